// File: rtl/data_mem_param.sv
// data_mem_param: parameterised single-port data memory with registered read,
// write-first forwarding and out-of-range detection. Define DATA_MEM_CLEAR_EN for the reset-time clear/preload sweep.
module data_mem_param #(
  parameter int DW            = 8,
  parameter int AW            = 8,
  parameter int DEPTH         = 256,
  parameter int PRELOAD_ADDR0 = 16,
  parameter int PRELOAD_VAL0  = 254,
  parameter int PRELOAD_ADDR1 = 244,
  parameter int PRELOAD_VAL1  = 5
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          ready,
  output logic          range_err
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

  logic [DW-1:0] core [DEPTH];
  logic          in_range;
  logic [IW-1:0] idx;
  logic          sweep_we;
  logic [IW-1:0] sweep_addr;
  logic [DW-1:0] sweep_data;
  logic          mem_we;
  logic [IW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  // Extra top bit so DEPTH == 2**AW compares correctly.
  assign in_range = {1'b0, addr} < DEPTH_A;
  assign idx      = addr[IW-1:0];

  function automatic logic [DW-1:0] preload_val(input logic [CW-1:0] a);
    if (int'(a) == PRELOAD_ADDR0) return DW'(PRELOAD_VAL0);
    if (int'(a) == PRELOAD_ADDR1) return DW'(PRELOAD_VAL1);
    return '0;
  endfunction

`ifdef DATA_MEM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sweep_we   = !reset && (state == CLEAR);
  assign sweep_addr = cnt[IW-1:0];
  assign sweep_data = preload_val(cnt);
`else
  always_ff @(posedge CLK) ready <= !reset;

  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
  assign sweep_data = preload_val('0);
`endif

  always_comb begin
    mem_we = 1'b0;
    mem_wa = idx;
    mem_wd = wr_data;
    if (sweep_we) begin
      mem_we = 1'b1;
      mem_wa = sweep_addr;
      mem_wd = sweep_data;
    end else if (!reset && ready && wr_en && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) core[mem_wa] <= mem_wd;
  end

  // Same-edge write wins over the stored word; out-of-range reads return zero.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      rd_valid <= ready && rd_en;
      if (ready && rd_en)
        rd_data <= !in_range ? '0 : (wr_en ? wr_data : core[idx]);
      if (ready && (rd_en || wr_en) && !in_range)
        range_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_mem_param.sv
// Self-checking bench for data_mem_param (DEPTH=16): directed steps plus random traffic
// checked against an array-based reference model.
module tb_data_mem_param;
  localparam int DW = 8, AW = 8, DEPTH = 16;
  localparam int PA0 = 4, PV0 = 254, PA1 = 9, PV1 = 5;

  logic          CLK = 1'b0;
  logic          reset = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, ready, range_err;

  always #5 CLK = ~CLK;

  data_mem_param #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH),
    .PRELOAD_ADDR0(PA0), .PRELOAD_VAL0(PV0),
    .PRELOAD_ADDR1(PA1), .PRELOAD_VAL1(PV1)
  ) dut (
    .CLK(CLK), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .ready(ready), .range_err(range_err)
  );

  int n_cmp = 0, n_bad = 0;

  logic [DW-1:0] mdl [DEPTH];
  bit            known [DEPTH];
  bit            m_ready = 0, m_valid = 0, m_err = 0, m_rd_known = 0;
  logic [DW-1:0] m_rd = '0;
  int            sweep_left = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model by the behavioural rules, compare.
  task automatic cyc(bit rst, bit rd, bit wr, int a, logic [DW-1:0] d);
    reset = rst; rd_en = rd; wr_en = wr; addr = AW'(a); wr_data = d;
    @(posedge CLK); #1;
    m_valid = 0;
    if (rst) begin
      m_ready = 0; m_err = 0; m_rd = '0; m_rd_known = 1; sweep_left = DEPTH;
    end else if (!m_ready) begin
`ifdef DATA_MEM_CLEAR_EN
      sweep_left--;
      if (sweep_left == 0) begin
        m_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 1; end
        mdl[PA1] = DW'(PV1);
        mdl[PA0] = DW'(PV0);
      end
`else
      m_ready = 1;
`endif
    end else if (a < DEPTH) begin
      if (wr) begin mdl[a] = d; known[a] = 1; end
      if (rd) begin m_valid = 1; m_rd = mdl[a]; m_rd_known = known[a]; end
    end else if (rd || wr) begin
      m_err = 1;
      if (rd) begin m_valid = 1; m_rd = '0; m_rd_known = 1; end
    end
    chk("ready", 32'(ready), 32'(m_ready));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("range_err", 32'(range_err), 32'(m_err));
    if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
    @(negedge CLK);
  endtask

  initial begin
    bit mid = 0;
    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; known[i] = 0; end

    cyc(1, 0, 0, 0, 0);
    // Sweep window: random ignored requests, a write to 2, and one mid-sweep reset.
    for (int i = 0; i < 60 && !m_ready; i++) begin
      if (i == 7 && !mid) begin mid = 1; cyc(1, 0, 0, 0, 0); end
      else if (i == 3) cyc(0, 0, 1, 2, 8'hEE);
      else cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 23)), DW'($urandom));
    end
    chk("ready_reached", 32'(ready), 32'd1);

    cyc(0, 1, 0, 4, 0);
    cyc(0, 1, 0, 9, 0);
    cyc(0, 1, 0, 3, 0);
    cyc(0, 1, 0, 2, 0);

    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, i, DW'($urandom));

    cyc(0, 0, 1, 5, 8'hA5);
    cyc(0, 1, 0, 5, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 7, 8'h11);
    cyc(0, 1, 1, 7, 8'h3C);
    cyc(0, 1, 0, 7, 0);
    cyc(0, 0, 1, 20, 8'h77);
    cyc(0, 1, 0, 4, 0);
    cyc(0, 1, 0, 20, 0);
    cyc(0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++)
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 23)), DW'($urandom));

    cyc(0, 0, 1, 3, 8'h5A);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 60 && !m_ready; i++) cyc(0, 0, 0, 0, 0);
    chk("ready_after_reset", 32'(ready), 32'd1);
    cyc(0, 1, 0, 3, 0);
    cyc(0, 1, 0, 4, 0);
    cyc(0, 1, 0, 9, 0);
    cyc(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_param.md
# data_mem_param

Parametrised single-port data memory for the CSE141L core: one address pointer shared by read and write, generalised in data width and depth. Adds a registered read with a valid strobe, write-first collision forwarding, out-of-range detection, and a reset-time clear/preload sweep gated by a `ready` flag. Sits between the core's load/store datapath and the program's data space, replacing the fixed 256×8 memory.

## Interface
- `DW`, default 8: data word width in bits.
- `AW`, default 8: address width in bits.
- `DEPTH`, default 256: number of words; must satisfy 2 ≤ DEPTH ≤ 2^AW.
- `PRELOAD_ADDR0`, default 16: first preload address.
- `PRELOAD_VAL0`, default 254: value loaded at `PRELOAD_ADDR0`.
- `PRELOAD_ADDR1`, default 244: second preload address; ignored if ≥ DEPTH.
- `PRELOAD_VAL1`, default 5: value loaded at `PRELOAD_ADDR1`.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `addr` in AW: shared read/write word address.
- `rd_en` in 1: read request.
- `wr_en` in 1: write request.
- `wr_data` in DW: write data.
- `rd_data` out DW: registered read data.
- `rd_valid` out 1: `rd_data` updated by the previous edge.
- `ready` out 1: memory accepts requests.
- `range_err` out 1: sticky flag for an accepted access with `addr` ≥ DEPTH.

## Operation
- States: CLEAR, READY.
- Reset edge: state → CLEAR, sweep counter → 0, `ready` = 0, `rd_valid` = 0, `rd_data` = 0, `range_err` = 0.
- CLEAR: each non-reset edge writes `core[cnt]` and increments `cnt` by 1.
  - Written value is `PRELOAD_VAL0` if `cnt` == `PRELOAD_ADDR0`.
  - Else `PRELOAD_VAL1` if `cnt` == `PRELOAD_ADDR1`.
  - Else 0.
  - `ADDR0` wins if both addresses are equal.
- The edge that writes word DEPTH−1 moves the state to READY and sets `ready` = 1.
- While `ready` = 0: `rd_en` and `wr_en` are ignored, with no memory change, `rd_valid` = 0, and no `range_err`.
- READY, write: `wr_en` with `addr` < DEPTH writes `core[addr]` = `wr_data` at the edge.
- READY, read: `rd_en` with `addr` < DEPTH sets `rd_data` = `core[addr]` and `rd_valid` = 1 at the edge.
- `rd_en` and `wr_en` together on the same edge: the write-first rule applies and `rd_data` = `wr_data`.
- Out-of-range access (`addr` ≥ DEPTH, `rd_en` or `wr_en`, READY):
  - The write is dropped; there is no aliasing.
  - A read returns `rd_data` = 0 with `rd_valid` = 1.
  - `range_err` is set and stays set until reset.
- Edge with no read accepted: `rd_valid` = 0 and `rd_data` holds its last value.
- Reset asserted mid-sweep or in READY restarts from CLEAR with `cnt` = 0. Memory contents are not otherwise guaranteed until the sweep completes.

## Timing
- Read latency is 1 cycle. Request sampled at edge N; `rd_data` and `rd_valid` are valid after edge N, until edge N+1.
- Write is visible to a read issued at the next edge. A same-edge read of the same address is forwarded.
- With the clear feature, `ready` rises exactly DEPTH edges after the last reset edge.
- Holding `reset` high keeps `cnt` = 0 and `ready` = 0.
- `ready` is registered, so there is no combinational path from inputs to any output.
- `cnt` is ⌈log2(DEPTH+1)⌉ bits wide and saturates logically: the state leaves CLEAR at DEPTH−1 and the counter never wraps.

## Configuration
- `DATA_MEM_CLEAR_EN` defined: the CLEAR sweep and preload behave as above.
- Not defined:
  - No sweep logic and no preload.
  - A reset edge clears `ready`, `rd_valid`, `rd_data` and `range_err`.
  - The first non-reset edge sets `ready` = 1.
  - Memory contents are retained across reset; they are X after power-up in simulation.

## Test plan
- Clear/preload, `DATA_MEM_CLEAR_EN`, DEPTH=16, `PRELOAD_ADDR1`=9, `PRELOAD_VAL0`=254, `PRELOAD_ADDR0`=4: after a one-cycle reset, `ready` stays 0 for 15 edges and goes to 1 on the 16th. Reads then return `addr` 4 → 254, `addr` 9 → 5, `addr` 3 → 0.
- Write/read: write 0xA5 to `addr` 5, then read `addr` 5 on the next edge → `rd_valid` = 1 and `rd_data` = 0xA5 one cycle later; a following idle edge → `rd_valid` = 0, `rd_data` still 0xA5.
- Collision: `rd_en`, `wr_en`, `addr` 7, `wr_data` 0x3C on one edge (old value 0x11) → `rd_data` = 0x3C.
- Range, DEPTH=16: write 0x77 to `addr` 20 → `range_err` = 1 and `addr` 4 is unchanged; a read of `addr` 20 → `rd_data` = 0, `rd_valid` = 1. `range_err` stays 1 until reset.
- Reset mid-sweep: assert reset at sweep edge 8 for one cycle → `ready` = 1 exactly 16 edges after release. A write to `addr` 2 issued during CLEAR is ignored; `addr` 2 reads 0.
- Macro undefined: write 0x5A to `addr` 3, pulse reset → `ready` = 1 after 1 edge, and a read of `addr` 3 returns 0x5A.
